// File: rtl/ex_md_stage.sv
// Execute stage with iterative RV32M/RV64M multiply/divide unit.
// Owns the EX/MEM register; M-ops stall ID/EX through in_ready.
module ex_md_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [1:0]      wb_ctl,
  input  logic [2:0]      m_ctl,
  input  logic            regdst,
  input  logic            alusrc,
  input  logic [1:0]      aluop,
  input  logic            md_en,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] npc,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [XLEN-1:0] imm,
  input  logic [RA_W-1:0] instr_2016,
  input  logic [RA_W-1:0] instr_1511,
  output logic            out_valid,
  output logic [1:0]      wb_ctlout,
  output logic            branch,
  output logic            memread,
  output logic            memwrite,
  output logic [XLEN-1:0] ex_mem_npc,
  output logic            zero,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] rdata2out,
  output logic [RA_W-1:0] rd_out,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ITER = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d, a_q, a_d;
  logic            mul_q, mul_d, neg_q, neg_d;
  logic            negr_q, negr_d, div0_q, div0_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      pwb_q, pwb_d;
  logic [2:0]      pm_q, pm_d;
  logic [RA_W-1:0] prd_q, prd_d;
  logic [XLEN-1:0] pnpc_q, pnpc_d, prd2_q, prd2_d;

  logic            ov_q, ov_d;
  logic [1:0]      wb_q, wb_d;
  logic [2:0]      m_q, m_d;
  logic [XLEN-1:0] npc_q, npc_d, res_q, res_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic            zero_q, zero_d;
  logic [RA_W-1:0] rd_q, rd_d;

  logic            busy_w, is_md, mulop, sa, sb;
  logic [XLEN-1:0] ma, mb, opb, alu_res, md_res;
  logic [XLEN-1:0] hi_n, lo_n, rsub, q_v, r_v;
  logic [XLEN:0]   sum, rsh;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [SW-1:0]   shamt;
  logic            unused_f7;

  assign busy_w    = (state_q == S_ITER);
  assign busy      = busy_w;
  assign in_ready  = ~busy_w;
  assign is_md     = md_en && (aluop == 2'b10);
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  // Single-cycle ALU on the incoming operands
  always_comb begin
    opb     = alusrc ? imm : rdata2;
    shamt   = opb[SW-1:0];
    alu_res = '0;
    if (aluop == 2'b00) begin
      alu_res = rdata1 + opb;
    end else if (aluop == 2'b01) begin
      alu_res = rdata1 - opb;
    end else begin
      unique case (funct3)
        3'b000: alu_res = (aluop == 2'b10 && funct7[5])
                          ? rdata1 - opb : rdata1 + opb;
        3'b001: alu_res = rdata1 << shamt;
        3'b010: alu_res = {{(XLEN-1){1'b0}},
                           ($signed(rdata1) < $signed(opb))};
        3'b011: alu_res = {{(XLEN-1){1'b0}}, (rdata1 < opb)};
        3'b100: alu_res = rdata1 ^ opb;
        3'b101: alu_res = funct7[5]
                          ? $unsigned($signed(rdata1) >>> shamt)
                          : rdata1 >> shamt;
        3'b110: alu_res = rdata1 | opb;
        default: alu_res = rdata1 & opb;
      endcase
    end
  end

  // Operand signs and magnitudes for the M unit at issue
  always_comb begin
    mulop = ~funct3[2];
    if (mulop) begin
      sa = (funct3[1] ^ funct3[0]) & rdata1[XLEN-1];
      sb = (funct3 == 3'b001) & rdata2[XLEN-1];
    end else begin
      sa = ~funct3[0] & rdata1[XLEN-1];
      sb = ~funct3[0] & rdata2[XLEN-1];
    end
    ma = sa ? -rdata1 : rdata1;
    mb = sb ? -rdata2 : rdata2;
  end

  // One shift-add / restoring-divide step plus sign fix-up
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rsh  = {hi_q, lo_q[XLEN-1]};
    rsub = rsh[XLEN-1:0] - opnd_q;
    if (mul_q) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end else if (rsh >= {1'b0, opnd_q}) begin
      hi_n = rsub;
      lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_n = rsh[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b0};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    q_v    = neg_q ? -lo_n : lo_n;
    r_v    = negr_q ? -hi_n : hi_n;
    if (div0_q) begin
      q_v = '1;
      r_v = a_q;
    end
    if (mul_q) begin
      md_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                    : prod_s[2*XLEN-1:XLEN];
    end else begin
      md_res = f3_q[1] ? r_v : q_v;
    end
  end

  // Issue, iteration and EX/MEM next-state; default is a bubble
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    f3_d    = f3_q;
    pwb_d   = pwb_q;
    pm_d    = pm_q;
    prd_d   = prd_q;
    pnpc_d  = pnpc_q;
    prd2_d  = prd2_q;
    ov_d    = 1'b0;
    wb_d    = 2'b00;
    m_d     = 3'b000;
    npc_d   = npc_q;
    res_d   = res_q;
    zero_d  = zero_q;
    rd2_d   = rd2_q;
    rd_d    = rd_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (busy_w) begin
      hi_d = hi_n;
      lo_d = lo_n;
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        ov_d    = 1'b1;
        wb_d    = pwb_q;
        m_d     = pm_q;
        npc_d   = pnpc_q;
        res_d   = md_res;
        zero_d  = (md_res == '0);
        rd2_d   = prd2_q;
        rd_d    = prd_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (in_valid) begin
      if (is_md) begin
        state_d = S_ITER;
        cnt_d   = SW'(XLEN-1);
        hi_d    = '0;
        lo_d    = mulop ? mb : ma;
        opnd_d  = mulop ? ma : mb;
        a_d     = rdata1;
        mul_d   = mulop;
        neg_d   = sa ^ sb;
        negr_d  = sa;
        div0_d  = (rdata2 == '0);
        f3_d    = funct3;
        pwb_d   = wb_ctl;
        pm_d    = m_ctl;
        prd_d   = regdst ? instr_1511 : instr_2016;
        pnpc_d  = npc + imm;
        prd2_d  = rdata2;
      end else begin
        ov_d   = 1'b1;
        wb_d   = wb_ctl;
        m_d    = m_ctl;
        npc_d  = npc + imm;
        res_d  = alu_res;
        zero_d = (alu_res == '0);
        rd2_d  = rdata2;
        rd_d   = regdst ? instr_1511 : instr_2016;
      end
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      f3_q    <= '0;
      pwb_q   <= '0;
      pm_q    <= '0;
      prd_q   <= '0;
      pnpc_q  <= '0;
      prd2_q  <= '0;
      ov_q    <= 1'b0;
      wb_q    <= '0;
      m_q     <= '0;
      npc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      rd2_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      f3_q    <= f3_d;
      pwb_q   <= pwb_d;
      pm_q    <= pm_d;
      prd_q   <= prd_d;
      pnpc_q  <= pnpc_d;
      prd2_q  <= prd2_d;
      ov_q    <= ov_d;
      wb_q    <= wb_d;
      m_q     <= m_d;
      npc_q   <= npc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      rd2_q   <= rd2_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid  = ov_q;
  assign wb_ctlout  = wb_q;
  assign branch     = m_q[2];
  assign memread    = m_q[1];
  assign memwrite   = m_q[0];
  assign ex_mem_npc = npc_q;
  assign zero       = zero_q;
  assign alu_result = res_q;
  assign rdata2out  = rd2_q;
  assign rd_out     = rd_q;

endmodule

// File: tb/tb_ex_md_stage.sv
// Directed bench for ex_md_stage: ALU, M-ops, divide corners,
// flush, reset mid-iteration and a 64-bit mulhu.
module tb_ex_md_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, regdst, alusrc, md_en;
  logic [1:0]  wb_ctl, aluop;
  logic [2:0]  m_ctl, funct3;
  logic [6:0]  funct7;
  logic [31:0] npc, rdata1, rdata2, imm;
  logic [4:0]  instr_2016, instr_1511;
  logic        in_ready, out_valid, branch, memread, memwrite;
  logic        zero, busy;
  logic [1:0]  wb_ctlout;
  logic [31:0] ex_mem_npc, alu_result, rdata2out;
  logic [4:0]  rd_out;

  logic        w_in_valid, w_in_ready, w_out_valid, w_branch;
  logic        w_memread, w_memwrite, w_zero, w_busy;
  logic [1:0]  w_wb_ctlout;
  logic [63:0] w_npc, w_rd1, w_rd2, w_imm;
  logic [63:0] w_ex_mem_npc, w_alu_result, w_rdata2out;
  logic [4:0]  w_rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  ex_md_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .wb_ctl(wb_ctl),
    .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .md_en(md_en), .funct3(funct3),
    .funct7(funct7), .npc(npc), .rdata1(rdata1),
    .rdata2(rdata2), .imm(imm), .instr_2016(instr_2016),
    .instr_1511(instr_1511), .out_valid(out_valid),
    .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite),
    .ex_mem_npc(ex_mem_npc), .zero(zero),
    .alu_result(alu_result), .rdata2out(rdata2out),
    .rd_out(rd_out), .busy(busy)
  );

  ex_md_stage #(.XLEN(64), .RA_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid),
    .in_ready(w_in_ready), .flush(flush), .wb_ctl(wb_ctl),
    .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .md_en(md_en), .funct3(funct3),
    .funct7(funct7), .npc(w_npc), .rdata1(w_rd1),
    .rdata2(w_rd2), .imm(w_imm), .instr_2016(instr_2016),
    .instr_1511(instr_1511), .out_valid(w_out_valid),
    .wb_ctlout(w_wb_ctlout), .branch(w_branch),
    .memread(w_memread), .memwrite(w_memwrite),
    .ex_mem_npc(w_ex_mem_npc), .zero(w_zero),
    .alu_result(w_alu_result), .rdata2out(w_rdata2out),
    .rd_out(w_rd_out), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input logic [1:0] op, input logic src,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] exp,
                         input string tag);
    @(negedge clk);
    md_en = 1'b0; aluop = op; alusrc = src; funct3 = f3;
    funct7 = f7; rdata1 = a; rdata2 = b; imm = im;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_res"}, alu_result, exp);
    chk({tag, "_zero"}, zero, (exp == 32'h0));
    chk({tag, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic md_run(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string tag);
    int busy_n;
    int bad_mw;
    bit done;
    @(negedge clk);
    md_en = 1'b1; aluop = 2'b10; funct3 = f3; funct7 = 7'b0000001;
    rdata1 = a; rdata2 = b; m_ctl = 3'b001; wb_ctl = 2'b10;
    alusrc = 1'b1; imm = 32'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    md_en = 1'b0; rdata1 = $urandom; rdata2 = $urandom;
    m_ctl = 3'b000; wb_ctl = 2'b00; funct3 = 3'b000;
    busy_n = 0; bad_mw = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (i == 4) in_valid = 1'b0;
      if (out_valid) done = 1'b1;
      else begin
        if (busy && !in_ready) busy_n++;
        if (memwrite) bad_mw++;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_res"}, alu_result, exp);
    chk({tag, "_busy_cycles"}, busy_n, 32);
    chk({tag, "_bubble_mw"}, bad_mw, 0);
    chk({tag, "_mw"}, memwrite, 1'b1);
    chk({tag, "_wb"}, wb_ctlout, 2'b10);
    chk({tag, "_ready"}, in_ready, 1'b1);
    @(negedge clk);
    chk({tag, "_one_pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    int pulses;
    int wbusy;
    bit wdone;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; regdst = 1'b0;
    alusrc = 1'b0; md_en = 1'b0; wb_ctl = 2'b00; aluop = 2'b00;
    m_ctl = 3'b000; funct3 = 3'b000; funct7 = 7'b0;
    npc = '0; rdata1 = '0; rdata2 = '0; imm = '0;
    instr_2016 = 5'd0; instr_1511 = 5'd0;
    w_in_valid = 1'b0; w_npc = '0; w_rd1 = '0; w_rd2 = '0;
    w_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_res", alu_result, 32'h0);
    chk("rst_npc", ex_mem_npc, 32'h0);
    chk("rst_ctl", {wb_ctlout, branch, memread, memwrite}, 5'b0);
    chk("rst_rd", rd_out, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_w_busy", w_busy, 1'b0);
    reset = 1'b0;

    regdst = 1'b1; instr_1511 = 5'd3; instr_2016 = 5'd9;
    wb_ctl = 2'b11; m_ctl = 3'b001; npc = 32'h100;
    alu_vec(2'b10, 1'b0, 3'b000, 7'b0100000, 32'd5, 32'd7,
            32'h10, 32'hFFFFFFFE, "sub");
    chk("sub_npc", ex_mem_npc, 32'h110);
    chk("sub_rd", rd_out, 5'd3);
    chk("sub_mw", memwrite, 1'b1);
    chk("sub_rd2", rdata2out, 32'd7);
    @(negedge clk);
    chk("bub_valid", out_valid, 1'b0);
    chk("bub_mw", memwrite, 1'b0);
    chk("bub_hold", alu_result, 32'hFFFFFFFE);

    regdst = 1'b0;
    alu_vec(2'b11, 1'b1, 3'b000, 7'b0100000, 32'd5, 32'd99,
            32'h10, 32'h15, "addi");
    chk("addi_rd", rd_out, 5'd9);
    alu_vec(2'b01, 1'b0, 3'b000, 7'b0, 32'd7, 32'd7,
            32'h0, 32'h0, "sub00");
    alu_vec(2'b10, 1'b0, 3'b101, 7'b0100000, 32'h80000000,
            32'd4, 32'h0, 32'hF8000000, "sra");
    alu_vec(2'b10, 1'b0, 3'b101, 7'b0, 32'h80000000,
            32'd4, 32'h0, 32'h08000000, "srl");
    alu_vec(2'b10, 1'b0, 3'b011, 7'b0, 32'd1, 32'hFFFFFFFF,
            32'h0, 32'd1, "sltu");
    alu_vec(2'b10, 1'b0, 3'b010, 7'b0, 32'd1, 32'hFFFFFFFF,
            32'h0, 32'd0, "slt");
    alu_vec(2'b11, 1'b1, 3'b001, 7'b0, 32'd3, 32'd0,
            32'h24, 32'd48, "slli");

    md_run(3'b001, 32'h80000000, 32'd2, 32'hFFFFFFFF, "mulh");
    md_run(3'b000, 32'h00010000, 32'h00010001, 32'h00010000, "mul");
    md_run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    md_run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    md_run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "divovf");
    md_run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, "removf");
    md_run(3'b111, 32'd9, 32'd0, 32'd9, "remu0");
    md_run(3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, "divu0");
    md_run(3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem0");
    md_run(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
    md_run(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
    md_run(3'b101, 32'd100, 32'd7, 32'd14, "divu");

    @(negedge clk);
    md_en = 1'b1; aluop = 2'b10; funct3 = 3'b101;
    rdata1 = 32'd100; rdata2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; md_en = 1'b0;
    repeat (22) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("flush_no_pulse", pulses, 0);
    alu_vec(2'b10, 1'b0, 3'b110, 7'b0, 32'hF0, 32'h0F,
            32'h0, 32'hFF, "after_flush_or");

    @(negedge clk);
    aluop = 2'b00; rdata1 = 32'd1; rdata2 = 32'd1; alusrc = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_valid", out_valid, 1'b0);
    chk("flush_idle_hold", alu_result, 32'hFF);

    @(negedge clk);
    md_en = 1'b1; aluop = 2'b10; funct3 = 3'b000;
    rdata1 = 32'd3; rdata2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; md_en = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_res", alu_result, 32'h0);
    chk("rstmid_valid", out_valid, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rstmid_no_pulse", pulses, 0);

    @(negedge clk);
    md_en = 1'b1; aluop = 2'b10; funct3 = 3'b011;
    w_rd1 = '1; w_rd2 = '1; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0; md_en = 1'b0; w_rd1 = '0; w_rd2 = '0;
    wbusy = 0; wdone = 1'b0;
    for (int i = 0; i < 200 && !wdone; i++) begin
      @(negedge clk);
      if (w_out_valid) wdone = 1'b1;
      else if (w_busy) wbusy++;
    end
    chk("mulhu64_done", wdone, 1'b1);
    chk("mulhu64_res", w_alu_result, 64'hFFFFFFFFFFFFFFFE);
    chk("mulhu64_busy", wbusy, 64);
    chk("mulhu64_ready", w_in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
